// File: rtl/fifo_cmd_adder_engine_pkg.sv
// Shared types and constants for the FIFO command/arithmetic kernel.
package fifo_cmd_adder_engine_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned TAG_W  = 16;

  localparam logic [OP_W-1:0] OP_ADD       = 4'h1;
  localparam logic [OP_W-1:0] OP_ACCUM     = 4'h2;
  localparam logic [OP_W-1:0] OP_PLUS_ONE  = 4'h3;
  localparam logic [OP_W-1:0] OP_TIMES_TWO = 4'h4;

  localparam logic [TAG_W-1:0] ERR_TAG = 16'hBAD0;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HDR_WAIT  = 3'd1,
    DECODE    = 3'd2,
    OPND_RD   = 3'd3,
    OPND_WAIT = 3'd4,
    WR_RES    = 3'd5
  } state_e;

  // Word pushed back to the host when the opcode is not recognised.
  typedef struct packed {
    logic [TAG_W-1:0]               tag;
    logic [DATA_W-TAG_W-OP_W-1:0]   pad;
    logic [OP_W-1:0]                opcode;
  } err_word_t;

  function automatic logic is_valid_op(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_ACCUM) || (op == OP_PLUS_ONE) || (op == OP_TIMES_TWO);
  endfunction

  // Ops that emit one result per operand group (as opposed to ACCUM's single sum).
  function automatic logic is_per_result_op(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_PLUS_ONE) || (op == OP_TIMES_TWO);
  endfunction

  function automatic logic [DATA_W-1:0] make_err_word(input logic [OP_W-1:0] op);
    err_word_t w;
    w.tag    = ERR_TAG;
    w.pad    = '0;
    w.opcode = op;
    return DATA_W'(w);
  endfunction

endpackage

// File: rtl/fifo_cmd_adder_engine_cl_adder_alu.sv
// Combinational 32-bit ALU: a+b for ADD/ACCUM, b+1 for PLUS_ONE, b<<1 for TIMES_TWO.
module cl_adder_alu
  import fifo_cmd_adder_engine_pkg::*;
(
  input  logic [OP_W-1:0]   opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (opcode)
      OP_ADD, OP_ACCUM: {carry, result} = (DATA_W+1)'(a) + (DATA_W+1)'(b);
      OP_PLUS_ONE:      {carry, result} = (DATA_W+1)'(b) + (DATA_W+1)'(1);
      OP_TIMES_TWO: begin
        result = {b[DATA_W-2:0], 1'b0};
        carry  = b[DATA_W-1];
      end
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fifo_cmd_adder_engine.sv
// Kernel that pops command/operand words from the host FIFO, computes, and pushes results back.
module fifo_cmd_adder_engine
  import fifo_cmd_adder_engine_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned CNT_W      = 16
)
(
  input  logic              clock,
  input  logic              reset,
  input  logic              data_empty,
  output logic              data_rd,
  input  logic [DATA_W-1:0] data_din,
  input  logic              data_full,
  output logic              data_wr,
  output logic [DATA_W-1:0] data_dout,
  output logic              busy,
  output logic [15:0]       cmd_done,
  output logic              err_sticky,
  output logic              carry_sticky
);

  localparam int unsigned WAIT_W = 2;
  localparam int unsigned DONE_W = 16;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LATENCY);

  state_e              state;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [OP_W-1:0]     opcode;
  logic [CNT_W-1:0]    remaining;
  logic [DATA_W-1:0]   acc;
  logic [DATA_W-1:0]   res;
  logic                second;

  logic [DATA_W-1:0]   alu_result;
  logic                alu_carry;

  // acc holds the first ADD operand or the running ACCUM sum; din is always b.
  cl_adder_alu u_alu (
    .opcode (opcode),
    .a      (acc),
    .b      (data_din),
    .result (alu_result),
    .carry  (alu_carry)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      opcode       <= '0;
      remaining    <= '0;
      acc          <= '0;
      res          <= '0;
      second       <= 1'b0;
      data_rd      <= 1'b0;
      data_wr      <= 1'b0;
      data_dout    <= '0;
      busy         <= 1'b0;
      cmd_done     <= '0;
      err_sticky   <= 1'b0;
      carry_sticky <= 1'b0;
    end else begin
      data_rd <= 1'b0;
      data_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (!data_empty) begin
            data_rd  <= 1'b1;
            wait_cnt <= '0;
            busy     <= 1'b1;
            state    <= HDR_WAIT;
          end
        end

        HDR_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            opcode    <= data_din[DATA_W-1 -: OP_W];
            remaining <= data_din[CNT_W-1:0];
            state     <= DECODE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        DECODE: begin
          if (!is_valid_op(opcode)) begin
            res        <= make_err_word(opcode);
            err_sticky <= 1'b1;
            state      <= WR_RES;
          end else if (remaining == '0) begin
            if (opcode == OP_ACCUM) begin
              res   <= '0;
              state <= WR_RES;
            end else begin
              cmd_done <= cmd_done + DONE_W'(1);
              busy     <= 1'b0;
              state    <= IDLE;
            end
          end else begin
            acc    <= '0;
            second <= 1'b0;
            state  <= OPND_RD;
          end
        end

        OPND_RD: begin
          if (!data_empty) begin
            data_rd  <= 1'b1;
            wait_cnt <= '0;
            state    <= OPND_WAIT;
          end
        end

        OPND_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            case (opcode)
              OP_ADD: begin
                if (!second) begin
                  acc    <= data_din;
                  second <= 1'b1;
                  state  <= OPND_RD;
                end else begin
                  res <= alu_result;
                  if (alu_carry) carry_sticky <= 1'b1;
                  state <= WR_RES;
                end
              end
              OP_ACCUM: begin
                acc       <= alu_result;
                res       <= alu_result;
                remaining <= remaining - CNT_W'(1);
                if (alu_carry) carry_sticky <= 1'b1;
                state <= (remaining == CNT_W'(1)) ? WR_RES : OPND_RD;
              end
              default: begin
                res <= alu_result;
                if (alu_carry) carry_sticky <= 1'b1;
                state <= WR_RES;
              end
            endcase
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        WR_RES: begin
          if (!data_full) begin
            data_wr   <= 1'b1;
            data_dout <= res;
            if (is_per_result_op(opcode) && (remaining != CNT_W'(1))) begin
              remaining <= remaining - CNT_W'(1);
              second    <= 1'b0;
              state     <= OPND_RD;
            end else begin
              remaining <= '0;
              cmd_done  <= cmd_done + DONE_W'(1);
              busy      <= 1'b0;
              state     <= IDLE;
            end
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
